// File: rtl/spi_master_rx.sv
// SPI mode-0 master receive engine: clocks N bytes in from MISO (MSB first)
// under one chip-select assertion and presents each byte as a one-cycle pulse.
module spi_master_rx #(
  parameter int          CLKS_PER_HALF_BIT = 2,
  parameter int          MAX_BYTES_PER_CS  = 2,
  parameter logic [7:0]  TX_FILL           = 8'h00
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_start,
  input  logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] i_num_bytes,
  output logic                                  o_ready,
  output logic                                  o_sclk,
  output logic                                  o_cs_n,
  output logic                                  o_mosi,
  input  logic                                  miso,
  output logic                                  o_rx_dv,
  output logic [7:0]                            o_rx_byte,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_rx_count,
  output logic                                  o_done
);

  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int EW = $clog2(16 * MAX_BYTES_PER_CS);
  localparam int HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, XFER, CS_HOLD, CS_IDLE} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [EW-1:0] edge_cnt;
  logic [EW-1:0] last_edge;
  logic [CW-1:0] last_idx;
  logic [6:0]    shift;
  logic [CW-1:0] num_clip;
  logic          half_done;

  assign num_clip  = (i_num_bytes > CW'(MAX_BYTES_PER_CS)) ? CW'(MAX_BYTES_PER_CS) : i_num_bytes;
  assign half_done = (half_cnt == HALF_LAST);

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      half_cnt   <= '0;
      edge_cnt   <= '0;
      last_edge  <= '0;
      last_idx   <= '0;
      shift      <= '0;
      o_ready    <= 1'b1;
      o_sclk     <= 1'b0;
      o_cs_n     <= 1'b1;
      o_mosi     <= 1'b0;
      o_rx_dv    <= 1'b0;
      o_rx_byte  <= '0;
      o_rx_count <= '0;
      o_done     <= 1'b0;
    end else begin
      o_rx_dv <= 1'b0;
      o_done  <= 1'b0;
      half_cnt <= half_done ? '0 : half_cnt + 1'b1;

      // Index advances the cycle after each byte pulse, parking on the last byte.
      if (o_rx_dv && (o_rx_count != last_idx))
        o_rx_count <= o_rx_count + 1'b1;

      case (state)
        IDLE: begin
          half_cnt <= '0;
          if (i_start && (i_num_bytes != '0)) begin
            state      <= CS_SETUP;
            last_edge  <= (EW'(num_clip) << 4) - EW'(1);
            last_idx   <= num_clip - 1'b1;
            o_cs_n     <= 1'b0;
            o_ready    <= 1'b0;
            o_mosi     <= TX_FILL[7];
            o_rx_count <= '0;
          end
        end

        CS_SETUP: begin
          if (half_done) begin
            state    <= XFER;
            edge_cnt <= '0;
          end
        end

        XFER: begin
          if (half_done) begin
            o_sclk   <= ~o_sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (!o_sclk) begin
              shift <= {shift[5:0], miso};
              if (edge_cnt[3:1] == 3'd7) begin
                o_rx_byte <= {shift, miso};
                o_rx_dv   <= 1'b1;
              end
            end else if (edge_cnt == last_edge) begin
              state <= CS_HOLD;
            end else begin
              // Wraps from bit 0 back to bit 7 at byte boundaries.
              o_mosi <= TX_FILL[3'd6 - edge_cnt[3:1]];
            end
          end
        end

        CS_HOLD: begin
          if (half_done) begin
            state  <= CS_IDLE;
            o_cs_n <= 1'b1;
            o_mosi <= 1'b0;
          end
        end

        CS_IDLE: begin
          if (half_done) begin
            state   <= IDLE;
            o_done  <= 1'b1;
            o_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_rx.sv
// Directed bench for spi_master_rx: a mode-0 slave model feeds MISO and a
// negedge monitor records pulses, SCLK edges and chip-select timing.
module tb_spi_master_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [1:0] i_num_bytes;
  logic       o_ready, o_sclk, o_cs_n, o_mosi, miso, o_rx_dv, o_done;
  logic [7:0] o_rx_byte;
  logic [1:0] o_rx_count;

  logic       i_start2;
  logic [1:0] i_num_bytes2;
  logic       o_ready2, o_sclk2, o_cs_n2, o_mosi2, o_rx_dv2, o_done2;
  logic [7:0] o_rx_byte2;
  logic [1:0] o_rx_count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_master_rx #(.CLKS_PER_HALF_BIT(2), .MAX_BYTES_PER_CS(2), .TX_FILL(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_bytes(i_num_bytes),
    .o_ready(o_ready), .o_sclk(o_sclk), .o_cs_n(o_cs_n), .o_mosi(o_mosi),
    .miso(miso), .o_rx_dv(o_rx_dv), .o_rx_byte(o_rx_byte),
    .o_rx_count(o_rx_count), .o_done(o_done)
  );

  spi_master_rx #(.CLKS_PER_HALF_BIT(2), .MAX_BYTES_PER_CS(2), .TX_FILL(8'h96)) u_dut_fill (
    .clk(clk), .rst_n(rst_n), .i_start(i_start2), .i_num_bytes(i_num_bytes2),
    .o_ready(o_ready2), .o_sclk(o_sclk2), .o_cs_n(o_cs_n2), .o_mosi(o_mosi2),
    .miso(1'b0), .o_rx_dv(o_rx_dv2), .o_rx_byte(o_rx_byte2),
    .o_rx_count(o_rx_count2), .o_done(o_done2)
  );

  // Slave: presents the next bit after every falling SCLK, MSB first.
  logic [15:0] slave_word = 16'h0;
  int          sbit = 0;
  always @(negedge o_sclk or posedge o_cs_n) begin
    if (o_cs_n) sbit <= 0;
    else        sbit <= sbit + 1;
  end
  assign miso = (sbit < 16) ? slave_word[15 - sbit] : 1'b0;

  // Monitor state, sampled on the falling clk edge.
  int         cyc = 0;
  int         dv_n, done_n, done_cyc, cs_low, rise_n, cs_rise_n;
  logic [7:0] dv_byte [8];
  logic [1:0] dv_cnt  [8];
  int         dv_cyc  [8];
  logic       sclk_q = 1'b0, cs_q = 1'b1;
  int         m_n = 0;
  logic       m_bits [8];
  logic       m_prev [8];
  logic       sclk2_q = 1'b0, mosi2_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (o_rx_dv && dv_n < 8) begin
      dv_byte[dv_n] = o_rx_byte;
      dv_cnt[dv_n]  = o_rx_count;
      dv_cyc[dv_n]  = cyc;
      dv_n++;
    end
    if (o_done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (!o_cs_n) cs_low++;
    if (o_sclk && !sclk_q) rise_n++;
    if (o_cs_n && !cs_q) cs_rise_n++;
    sclk_q = o_sclk;
    cs_q   = o_cs_n;
    if (o_sclk2 && !sclk2_q && m_n < 8) begin
      m_bits[m_n] = o_mosi2;
      m_prev[m_n] = mosi2_q;
      m_n++;
    end
    sclk2_q = o_sclk2;
    mosi2_q = o_mosi2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    dv_n = 0; done_n = 0; done_cyc = 0; cs_low = 0; rise_n = 0; cs_rise_n = 0;
  endtask

  // mode 0: plain; 1: i_start pulsed during the transfer; 2: i_start held high
  // through the end so the next request lands on the cycle after o_done.
  task automatic run_xfer(input logic [1:0] nb, input int mode, output int t_acc);
    @(negedge clk); #1;
    clear_mon();
    i_start = 1'b1;
    i_num_bytes = nb;
    @(negedge clk); #1;
    t_acc = cyc;
    i_start = (mode == 2);
    for (int i = 0; i < 200; i++) begin
      if (done_n != 0) break;
      @(negedge clk); #1;
      i_start = (done_n == 0) ? ((mode == 2) || (mode == 1 && i % 3 == 0)) : (mode == 2);
    end
    check("done_seen", done_n, 1);
  endtask

  int t_acc;

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_num_bytes = 2'd0;
    i_start2 = 1'b0; i_num_bytes2 = 2'd0;
    clear_mon();
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", o_ready, 1);
    check("rst_cs_n", o_cs_n, 1);
    check("rst_sclk", o_sclk, 0);
    check("rst_mosi", o_mosi, 0);
    check("rst_outs", {o_rx_dv, o_rx_byte, o_rx_count, o_done}, 0);
    rst_n = 1'b1;

    // Single byte 0x41.
    slave_word = 16'h4100;
    run_xfer(2'd1, 0, t_acc);
    check("n1_dv_count", dv_n, 1);
    check("n1_byte", dv_byte[0], 8'h41);
    check("n1_index", dv_cnt[0], 0);
    check("n1_dv_time", dv_cyc[0] - t_acc, 32);
    check("n1_done_time", done_cyc - t_acc, 38);
    check("n1_cs_low", cs_low, 36);
    check("n1_sclk_rises", rise_n, 8);
    check("n1_ready", o_ready, 1);
    check("n1_byte_hold", o_rx_byte, 8'h41);

    // Two bytes back to back.
    slave_word = 16'hA53C;
    run_xfer(2'd2, 0, t_acc);
    check("n2_dv_count", dv_n, 2);
    check("n2_byte0", {dv_byte[0], 6'd0, dv_cnt[0]}, {8'hA5, 8'd0});
    check("n2_byte1", {dv_byte[1], 6'd0, dv_cnt[1]}, {8'h3C, 8'd1});
    check("n2_dv_gap", dv_cyc[1] - dv_cyc[0], 32);
    check("n2_done_time", done_cyc - t_acc, 70);
    check("n2_cs_rises", cs_rise_n, 1);
    check("n2_sclk_rises", rise_n, 16);
    check("n2_count_sat", o_rx_count, 1);

    // Zero-byte request is ignored.
    @(negedge clk); #1;
    clear_mon();
    i_start = 1'b1; i_num_bytes = 2'd0;
    @(negedge clk); #1;
    i_start = 1'b0;
    check("zero_ready", o_ready, 1);
    repeat (5) @(negedge clk);
    #1;
    check("zero_cs_low", cs_low, 0);

    // Oversized request clipped to two bytes.
    slave_word = 16'h1234;
    run_xfer(2'd3, 0, t_acc);
    check("clip_dv_count", dv_n, 2);
    check("clip_bytes", {dv_byte[0], dv_byte[1]}, 16'h1234);
    check("clip_done_time", done_cyc - t_acc, 70);

    // Repeated i_start during the transfer changes nothing.
    slave_word = 16'h5AC3;
    run_xfer(2'd2, 1, t_acc);
    repeat (10) @(negedge clk);
    #1;
    check("spam_done_time", done_cyc - t_acc, 70);
    check("spam_done_n", done_n, 1);
    check("spam_dv_count", dv_n, 2);
    check("spam_idle", {o_ready, o_cs_n}, 2'b11);

    // i_start held through o_done: refused at the done edge, taken the next cycle.
    slave_word = 16'h8100;
    run_xfer(2'd1, 2, t_acc);
    check("hold_done_cycle_cs", o_cs_n, 1);
    @(negedge clk); #1;
    i_start = 1'b0;
    check("hold_accept_next", {o_cs_n, o_ready}, 2'b00);
    for (int i = 0; i < 200; i++) begin
      if (done_n >= 2) break;
      @(negedge clk); #1;
    end
    check("hold_second_done", done_n, 2);
    check("hold_bytes", {dv_byte[0], dv_byte[1]}, 16'h8181);

    // Reset after the 4th SCLK rise aborts cleanly.
    slave_word = 16'hC3C3;
    @(negedge clk); #1;
    clear_mon();
    i_start = 1'b1; i_num_bytes = 2'd2;
    @(negedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rise_n >= 4) break;
      @(negedge clk); #1;
    end
    check("abort_rises", rise_n, 4);
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    check("abort_state", {o_cs_n, o_sclk, o_ready, o_rx_dv}, 4'b1010);
    check("abort_byte", o_rx_byte, 0);
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_pulses", {dv_n[7:0], done_n[7:0]}, 0);
    slave_word = 16'hFF00;
    run_xfer(2'd1, 0, t_acc);
    check("abort_recover", {dv_n[7:0], dv_byte[0]}, {8'd1, 8'hFF});

    // MOSI fill pattern on the second instance.
    @(negedge clk); #1;
    i_start2 = 1'b1; i_num_bytes2 = 2'd1;
    @(negedge clk); #1;
    i_start2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (o_ready2) break;
      @(negedge clk); #1;
    end
    check("fill_rises", m_n, 8);
    begin
      logic [7:0] fill;
      fill = 8'h96;
      for (int i = 0; i < 8; i++) begin
        check($sformatf("fill_bit%0d", i), m_bits[i], fill[7-i]);
        check($sformatf("fill_stable%0d", i), m_prev[i], fill[7-i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
